digest_uart_tx_feeder: RTL and testbench
========================================

# digest_uart_tx_feeder

Upstream feeder for the byte-wide UART transmitter. Captures a completed SHA-256 digest from the hash core and streams it out one byte at a time over the transmitter's `i_Tx_DV`/`i_Tx_Byte`/`o_Tx_Active`/`o_Tx_Done` handshake. Sits between the hash core's digest output and the UART TX stage.

## Interface
- `DIGEST_WIDTH`, 256: digest width in bits; must be a multiple of 8.
- `UART_DATA_WIDTH`, 8: byte width presented to the transmitter.
- `i_Clock`  in  1: single clock. Shared with the transmitter.
- `i_Reset`  in  1: reset, synchronous, active-high.
- `i_Digest_DV`  in  1: one-cycle strobe; digest valid. Accepted only while `o_Ready`=1.
- `i_Digest`  in  DIGEST_WIDTH: digest value; sampled on an accepted `i_Digest_DV`.
- `o_Ready`  out  1: high in IDLE only.
- `o_Tx_DV`  out  1: one-cycle strobe to the transmitter's `i_Tx_DV`.
- `o_Tx_Byte`  out  UART_DATA_WIDTH: byte to the transmitter's `i_Tx_Byte`. Held stable from the `o_Tx_DV` cycle until the next load.
- `i_Tx_Active`  in  1: from the transmitter's `o_Tx_Active`.
- `i_Tx_Done`  in  1: from the transmitter's `o_Tx_Done`. The transmitter holds this high for 2 cycles per frame.
- `o_Busy`  out  1: high from digest accept until the FINISH state.
- `o_Done`  out  1: one-cycle pulse after the last frame completes.

## Operation
- Registers: `r_Digest` (DIGEST_WIDTH bits), `r_Byte_Cnt` (wide enough for DIGEST_WIDTH/8·2+2), and `r_Done_d` (previous `i_Tx_Done`, used for edge detection).
- States: IDLE, LOAD, STROBE, WAIT_ACTIVE, WAIT_DONE, FINISH.
- IDLE: `o_Ready`=1. On `i_Digest_DV`=1:
  - capture `i_Digest` into `r_Digest`;
  - clear `r_Byte_Cnt`;
  - go to LOAD.
- LOAD: compute the next byte into `o_Tx_Byte`, then go to STROBE.
- STROBE: `o_Tx_DV`=1 for exactly this cycle, then go to WAIT_ACTIVE.
- WAIT_ACTIVE: wait for `i_Tx_Active`=1, which confirms the transmitter accepted the byte. Then go to WAIT_DONE.
- WAIT_DONE: wait for a rising edge of `i_Tx_Done` (`i_Tx_Done`=1 and `r_Done_d`=0).
  - Only the edge is used; the 2-cycle level must never count twice.
  - On the edge: increment `r_Byte_Cnt`. If it was the last frame, go to FINISH; else go to LOAD.
- FINISH: `o_Done`=1 for one cycle, then go to IDLE.
- Byte order: MSB first. Byte n is `r_Digest[DIGEST_WIDTH-1-8n -: 8]`.
- `i_Digest_DV` outside IDLE is ignored. No queuing, no corruption of `r_Digest`.
- Reset mid-transfer:
  - all state returns to IDLE;
  - `o_Tx_DV` is forced low in the same cycle;
  - the transmitter finishes any frame already in flight, and the feeder ignores that frame's `i_Tx_Done`.

## Timing
- Reset values: `o_Ready`=1 (IDLE); `o_Tx_DV`=0; `o_Tx_Byte`=0; `o_Busy`=0; `o_Done`=0.
- All internal registers reset to 0.
- Digest accept (cycle 0) → LOAD (cycle 1) → `o_Tx_DV` (cycle 2).
- `i_Tx_Done` rising edge at cycle k → LOAD at k+1 → `o_Tx_DV` at k+2.
  - The transmitter is back in its idle state at k+1, so it samples the strobe at k+2.
- Inter-frame gap: 2 cycles of idle line plus the transmitter's idle cycle.
- `o_Ready` returns high the cycle after `o_Done`. A new digest can be accepted in that cycle.

## Configuration
- `DIGEST_HEX_ASCII_EN` defined:
  - each digest byte is sent as two lowercase ASCII hex characters, high nibble first ('0'–'9' = 0x30–0x39, 'a'–'f' = 0x61–0x66);
  - these are followed by CR (0x0D) then LF (0x0A);
  - 66 frames for a 256-bit digest.
- `DIGEST_HEX_ASCII_EN` undefined:
  - raw binary bytes only, no terminator;
  - 32 frames for a 256-bit digest.

## Test plan
- Reset, then idle for 10 cycles → `o_Ready`=1, `o_Tx_DV`=0, `o_Busy`=0, `o_Done`=0.
- Raw mode, SHA-256("abc") digest (0xba7816bf…f20015ad), connected to the real transmitter (104 clocks/bit):
  - exactly 32 `o_Tx_DV` pulses;
  - first byte 0xBA, last byte 0xAD;
  - a single `o_Done` pulse.
- Hex mode, same digest:
  - 66 frames;
  - frame 0 = 0x62 ('b'), frame 1 = 0x61 ('a'), frame 63 = 0x64 ('d'), frames 64–65 = 0x0D, 0x0A.
- With a transmitter model holding `i_Tx_Done` high for 2 cycles → one byte advance per frame and no skipped bytes. Check with digest 0x00010203…1F: bytes 0x00..0x1F in order.
- `i_Digest_DV` pulsed with a different digest during frame 5 → ignored; the output stream matches the original digest.
- `i_Reset` asserted during frame 10 →
  - `o_Tx_DV`=0 and `o_Ready`=1 one cycle after reset;
  - the in-flight frame's `i_Tx_Done` does not trigger a new strobe;
  - a new digest afterwards streams correctly from byte 0.

Source files
------------

// File: rtl/digest_uart_tx_feeder.sv
// digest_uart_tx_feeder
//   Captures a finished SHA-256 digest and streams it to the byte-wide UART
//   transmitter, MSB byte first, using the DV/Active/Done handshake.
//
//   Build option: DIGEST_HEX_ASCII_EN
//     When defined, each byte is sent as two lowercase ASCII hex characters
//     (high nibble first), followed by CR, LF.
//     When undefined, raw bytes are sent with no terminator.
//
// Ports
//   i_Clock      clock, shared with the transmitter
//   i_Reset      synchronous active-high reset
//   i_Digest_DV  digest strobe, accepted only while o_Ready=1
//   i_Digest     digest value, sampled on an accepted strobe
//   o_Ready      high in IDLE
//   o_Tx_DV      one-cycle strobe to the transmitter
//   o_Tx_Byte    byte to the transmitter, held until the next load
//   i_Tx_Active  transmitter busy
//   i_Tx_Done    transmitter frame done (2-cycle level)
//   o_Busy       high from digest accept until FINISH
//   o_Done       one-cycle pulse after the last frame completes
module digest_uart_tx_feeder #(
  parameter int DIGEST_WIDTH    = 256,
  parameter int UART_DATA_WIDTH = 8
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic                       i_Digest_DV,
  input  logic [DIGEST_WIDTH-1:0]    i_Digest,
  output logic                       o_Ready,
  output logic                       o_Tx_DV,
  output logic [UART_DATA_WIDTH-1:0] o_Tx_Byte,
  input  logic                       i_Tx_Active,
  input  logic                       i_Tx_Done,
  output logic                       o_Busy,
  output logic                       o_Done
);

  localparam int NBYTES = DIGEST_WIDTH / 8;
`ifdef DIGEST_HEX_ASCII_EN
  localparam int NFRAMES = NBYTES * 2 + 2;
`else
  localparam int NFRAMES = NBYTES;
`endif
  localparam int CNT_W = $clog2(NBYTES * 2 + 3);

  typedef enum logic [2:0] {
    IDLE, LOAD, STROBE, WAIT_ACTIVE, WAIT_DONE, FINISH
  } state_t;

  state_t                     r_State;
  logic [DIGEST_WIDTH-1:0]    r_Digest;
  logic [CNT_W-1:0]           r_Byte_Cnt;
  logic                       r_Done_d;
  logic                       r_Tx_DV;
  logic [DIGEST_WIDTH-1:0]    w_Shifted;
  logic [UART_DATA_WIDTH-1:0] w_Next_Byte;

`ifdef DIGEST_HEX_ASCII_EN
  logic [3:0] w_Nibble;

  // Frame f carries nibble f of the digest; two frames per digest byte.
  always_comb begin
    w_Shifted   = r_Digest << {r_Byte_Cnt[CNT_W-1:1], 3'b000};
    w_Nibble    = r_Byte_Cnt[0] ? w_Shifted[DIGEST_WIDTH-5 -: 4]
                                : w_Shifted[DIGEST_WIDTH-1 -: 4];
    w_Next_Byte = (w_Nibble < 4'd10) ? UART_DATA_WIDTH'(8'h30 + {4'h0, w_Nibble})
                                     : UART_DATA_WIDTH'(8'h57 + {4'h0, w_Nibble});
    if (r_Byte_Cnt == CNT_W'(2 * NBYTES))
      w_Next_Byte = UART_DATA_WIDTH'(8'h0D);
    else if (r_Byte_Cnt == CNT_W'(2 * NBYTES + 1))
      w_Next_Byte = UART_DATA_WIDTH'(8'h0A);
  end
`else
  always_comb begin
    w_Shifted   = r_Digest << {r_Byte_Cnt, 3'b000};
    w_Next_Byte = UART_DATA_WIDTH'(w_Shifted[DIGEST_WIDTH-1 -: 8]);
  end
`endif

  // Reset kills a pending strobe in the same cycle it is asserted.
  assign o_Tx_DV = r_Tx_DV & ~i_Reset;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State    <= IDLE;
      r_Digest   <= '0;
      r_Byte_Cnt <= '0;
      r_Done_d   <= 1'b0;
      r_Tx_DV    <= 1'b0;
      o_Tx_Byte  <= '0;
      o_Ready    <= 1'b1;
      o_Busy     <= 1'b0;
      o_Done     <= 1'b0;
    end else begin
      r_Done_d <= i_Tx_Done;
      r_Tx_DV  <= 1'b0;
      o_Done   <= 1'b0;
      case (r_State)
        IDLE: begin
          if (i_Digest_DV) begin
            r_Digest   <= i_Digest;
            r_Byte_Cnt <= '0;
            o_Ready    <= 1'b0;
            o_Busy     <= 1'b1;
            r_State    <= LOAD;
          end
        end
        // Hold off while the transmitter is still busy: after a mid-frame
        // reset the stale frame must drain before a new strobe can be taken.
        // In normal flow the line is already idle here.
        LOAD: begin
          if (!i_Tx_Active) begin
            o_Tx_Byte <= w_Next_Byte;
            r_Tx_DV   <= 1'b1;
            r_State   <= STROBE;
          end
        end
        STROBE: r_State <= WAIT_ACTIVE;
        WAIT_ACTIVE: begin
          if (i_Tx_Active) r_State <= WAIT_DONE;
        end
        // Only the rising edge of the 2-cycle Done level advances the count.
        WAIT_DONE: begin
          if (i_Tx_Done && !r_Done_d) begin
            r_Byte_Cnt <= r_Byte_Cnt + 1'b1;
            if (r_Byte_Cnt == CNT_W'(NFRAMES - 1)) begin
              o_Busy  <= 1'b0;
              o_Done  <= 1'b1;
              r_State <= FINISH;
            end else begin
              r_State <= LOAD;
            end
          end
        end
        FINISH: begin
          o_Ready <= 1'b1;
          r_State <= IDLE;
        end
        default: begin
          o_Ready <= 1'b1;
          o_Busy  <= 1'b0;
          r_State <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digest_uart_tx_feeder.sv
module tb_digest_uart_tx_feeder;

  localparam int DW    = 256;
  localparam int F_ACT = 12;   // active cycles per frame in the transmitter model
`ifdef DIGEST_HEX_ASCII_EN
  localparam int NF = 66;
`else
  localparam int NF = 32;
`endif

  localparam logic [DW-1:0] D_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [DW-1:0] D_CNT =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [DW-1:0] D_ALT = {32{8'hFF}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dig_dv = 1'b0;
  logic [DW-1:0] dig = '0;
  logic          ready, tx_dv, busy, done;
  logic [7:0]    tx_byte;
  logic          tx_active = 1'b0;
  logic          tx_done = 1'b0;
  int            ph = 0;
  int            act_cnt = 0;

  int            n_checks = 0;
  int            n_fail = 0;
  int            strobe_cnt = 0;
  int            done_cnt = 0;
  logic [7:0]    exp_q[$];
  logic [7:0]    rx_q[$];

  always #5 clk = ~clk;

  digest_uart_tx_feeder #(.DIGEST_WIDTH(DW), .UART_DATA_WIDTH(8)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Digest_DV(dig_dv), .i_Digest(dig),
    .o_Ready(ready), .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte),
    .i_Tx_Active(tx_active), .i_Tx_Done(tx_done), .o_Busy(busy), .o_Done(done)
  );

  // Transmitter model: never reset, so an in-flight frame survives a feeder
  // reset. Done is high for the cleanup cycle and the first idle cycle.
  always @(posedge clk) begin
    case (ph)
      0: begin
        tx_done <= 1'b0;
        if (tx_dv) begin
          tx_active <= 1'b1;
          act_cnt   <= 0;
          ph        <= 1;
        end
      end
      1: begin
        if (act_cnt == F_ACT - 1) begin
          tx_active <= 1'b0;
          tx_done   <= 1'b1;
          ph        <= 2;
        end else begin
          act_cnt <= act_cnt + 1;
        end
      end
      default: begin
        tx_done <= 1'b1;
        ph      <= 0;
      end
    endcase
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    case (n)
      4'h0: return 8'h30; 4'h1: return 8'h31; 4'h2: return 8'h32; 4'h3: return 8'h33;
      4'h4: return 8'h34; 4'h5: return 8'h35; 4'h6: return 8'h36; 4'h7: return 8'h37;
      4'h8: return 8'h38; 4'h9: return 8'h39; 4'hA: return 8'h61; 4'hB: return 8'h62;
      4'hC: return 8'h63; 4'hD: return 8'h64; 4'hE: return 8'h65; default: return 8'h66;
    endcase
  endfunction

  // Scoreboard monitor: compares every strobe and checks Done arrives only
  // after the whole stream has been sent.
  initial forever begin
    @(negedge clk);
    if (tx_dv) begin
      strobe_cnt++;
      check("tx_accepts_strobe", 32'(ph == 0), 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {24'h0, tx_byte}, 32'hFFFF_FFFF);
      end else begin
        check("stream_byte", {24'h0, tx_byte}, {24'h0, exp_q.pop_front()});
      end
      rx_q.push_back(tx_byte);
    end
    if (done) begin
      done_cnt++;
      check("done_after_last", exp_q.size(), 32'd0);
    end
  end

  task automatic push_stream(input logic [DW-1:0] d);
    logic [7:0] b;
    exp_q.delete();
    rx_q.delete();
    for (int i = 0; i < DW / 8; i++) begin
      b = d[DW-1-8*i -: 8];
`ifdef DIGEST_HEX_ASCII_EN
      exp_q.push_back(hexc(b[7:4]));
      exp_q.push_back(hexc(b[3:0]));
`else
      exp_q.push_back(b);
`endif
    end
`ifdef DIGEST_HEX_ASCII_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic pulse_digest(input logic [DW-1:0] d);
    dig    = d;
    dig_dv = 1'b1;
    @(posedge clk); #1;
    dig_dv = 1'b0;
  endtask

  task automatic wait_done(input int start, input string name);
    int k;
    k = 0;
    while (done_cnt == start && k < 5000) begin
      @(posedge clk); #2;
      k++;
    end
    check(name, 32'(done_cnt == start + 1), 32'd1);
    check("ready_after_done", {31'h0, ready}, 32'd1);
    check("done_single_pulse", {31'h0, done}, 32'd0);
  endtask

  task automatic wait_strobes(input int n);
    int k;
    k = 0;
    while (strobe_cnt < n && k < 5000) begin
      @(posedge clk); #1;
      k++;
    end
    check("strobe_reached", 32'(strobe_cnt >= n), 32'd1);
  endtask

  initial begin
    int s0;
    int d0;

    // Reset and idle.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("idle_ready", {31'h0, ready}, 32'd1);
    check("idle_tx_dv", {31'h0, tx_dv}, 32'd0);
    check("idle_busy",  {31'h0, busy},  32'd0);
    check("idle_done",  {31'h0, done},  32'd0);

    // abc digest with accept-to-strobe latency check.
    push_stream(D_ABC);
    s0 = strobe_cnt; d0 = done_cnt;
    pulse_digest(D_ABC);
    check("load_busy",  {31'h0, busy},  32'd1);
    check("load_ready", {31'h0, ready}, 32'd0);
    check("load_no_dv", {31'h0, tx_dv}, 32'd0);
    @(posedge clk); #1;
    check("strobe_cycle2", {31'h0, tx_dv}, 32'd1);
    wait_done(d0, "abc_done");
    check("abc_frames", strobe_cnt - s0, NF);
`ifdef DIGEST_HEX_ASCII_EN
    check("abc_frame0",  {24'h0, rx_q[0]},  32'h62);
    check("abc_frame1",  {24'h0, rx_q[1]},  32'h61);
    check("abc_frame63", {24'h0, rx_q[63]}, 32'h64);
    check("abc_frame64", {24'h0, rx_q[64]}, 32'h0D);
    check("abc_frame65", {24'h0, rx_q[65]}, 32'h0A);
`else
    check("abc_first", {24'h0, rx_q[0]},  32'hBA);
    check("abc_last",  {24'h0, rx_q[31]}, 32'hAD);
`endif

    // Counting digest, accepted in the cycle right after o_Done.
    push_stream(D_CNT);
    s0 = strobe_cnt; d0 = done_cnt;
    pulse_digest(D_CNT);
    wait_done(d0, "cnt_done");
    check("cnt_frames", strobe_cnt - s0, NF);

    // Foreign digest strobe during frame 5 must be ignored.
    push_stream(D_ABC);
    s0 = strobe_cnt; d0 = done_cnt;
    pulse_digest(D_ABC);
    wait_strobes(s0 + 6);
    repeat (3) @(posedge clk);
    #1;
    pulse_digest(D_ALT);
    check("ignore_ready", {31'h0, ready}, 32'd0);
    wait_done(d0, "ignore_done");
    check("ignore_frames", strobe_cnt - s0, NF);

    // Reset in frame 10; restart immediately while the frame is in flight.
    push_stream(D_CNT);
    s0 = strobe_cnt;
    pulse_digest(D_CNT);
    wait_strobes(s0 + 11);
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    rst = 1'b1;
    check("rst_tx_dv_now", {31'h0, tx_dv}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_tx_dv",  {31'h0, tx_dv}, 32'd0);
    check("rst_ready",  {31'h0, ready}, 32'd1);
    check("rst_busy",   {31'h0, busy},  32'd0);
    check("rst_inflight", {31'h0, tx_active}, 32'd1);
    push_stream(D_CNT);
    s0 = strobe_cnt; d0 = done_cnt;
    pulse_digest(D_CNT);
    wait_done(d0, "rst_restart_done");
    check("rst_restart_frames", strobe_cnt - s0, NF);
    check("rst_first_byte", {24'h0, rx_q[0]}, `ifdef DIGEST_HEX_ASCII_EN 32'h30 `else 32'h00 `endif);

    repeat (20) @(posedge clk);
    #1;
    check("total_done_pulses", done_cnt, 32'd4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
